// File: rtl/psg_ecfs_lvdcdc_sd_adc_ctrl.sv
// Sinc3 decimation tick, all-channel integrator capture and shared comb sequencer.
// Define SD_ADC_CTRL_FRAME_CNT_EN to add the out_frame sequence-number port.
module psg_ecfs_lvdcdc_sd_adc_ctrl #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DW     = 22
) (
   input  logic                 clk_adc,
   input  logic                 reset,
   input  logic                 en,
   input  logic [1:0]           dec_sel,
   input  logic [NUM_CH*DW-1:0] cn_in,
   output logic [DW-1:0]        out_data,
   output logic [2:0]           out_ch,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 overrun
`ifdef SD_ADC_CTRL_FRAME_CNT_EN
   ,
   output logic [15:0]          out_frame
`endif
);

   localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned CW  = 7;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_C1   = 3'd1;
   localparam logic [2:0] S_C2   = 3'd2;
   localparam logic [2:0] S_C3   = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;

   logic [1:0]    r_dsel;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_max;
   logic [DW-1:0] r_cap [NUM_CH];
   logic [DW-1:0] r_z1  [NUM_CH];
   logic [DW-1:0] r_z2  [NUM_CH];
   logic [DW-1:0] r_z3  [NUM_CH];
   logic [DW-1:0] r_d1;
   logic [DW-1:0] r_d2;
   logic [DW-1:0] w_d1;
   logic [DW-1:0] w_d2;
   logic [DW-1:0] w_d3;
   logic [2:0]    r_state;
   logic [2:0]    w_state_nxt;
   logic [2:0]    r_ch;
   logic [CHW-1:0] w_ci;
   logic [1:0]    r_settle;
   logic          w_tick;
   logic          w_ovr;
   logic          w_adv;
   logic          w_last;
   logic          w_settled;
   logic [DW-1:0] r_out_data;
   logic [2:0]    r_out_ch;
   logic          r_out_valid;
   logic          r_busy;
   logic          r_overrun;
`ifdef SD_ADC_CTRL_FRAME_CNT_EN
   logic [15:0]   r_frame;
   logic [15:0]   r_out_frame;
   assign out_frame = r_out_frame;
`endif

   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign overrun   = r_overrun;

   always_comb begin
      case (r_dsel)
         2'd0:    w_cnt_max = CW'(31);
         2'd1:    w_cnt_max = CW'(63);
         default: w_cnt_max = CW'(127);
      endcase
   end

   assign w_tick    = en && (r_cnt == w_cnt_max);
   assign w_ci      = r_ch[CHW-1:0];
   assign w_last    = (r_ch == 3'(NUM_CH - 1));
   assign w_settled = (r_settle == 2'd3);
   // Single shared subtractor path, one comb stage per cycle
   assign w_d1      = r_cap[w_ci] - r_z1[w_ci];
   assign w_d2      = r_d1 - r_z2[w_ci];
   assign w_d3      = r_d2 - r_z3[w_ci];

   always_comb begin
      w_state_nxt = r_state;
      w_ovr       = 1'b0;
      w_adv       = 1'b0;
      case (r_state)
         S_IDLE: if (w_tick) w_state_nxt = S_C1;
         S_C1:   w_state_nxt = S_C2;
         S_C2:   w_state_nxt = S_C3;
         S_C3: begin
            if (w_settled) w_state_nxt = S_OUT;
            else           w_adv       = 1'b1;
         end
         S_OUT:   w_adv = out_ready;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_adv) w_state_nxt = w_last ? S_IDLE : S_C1;
      // A tick landing mid-frame aborts it and restarts settling
      if (w_tick && (r_state != S_IDLE)) begin
         w_ovr       = 1'b1;
         w_state_nxt = S_IDLE;
      end
      if (!en) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk_adc) begin
      if (reset) begin
         r_dsel      <= dec_sel;
         r_cnt       <= '0;
         r_d1        <= '0;
         r_d2        <= '0;
         r_state     <= S_IDLE;
         r_ch        <= '0;
         r_settle    <= '0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            r_cap[k] <= '0;
            r_z1[k]  <= '0;
            r_z2[k]  <= '0;
            r_z3[k]  <= '0;
         end
`ifdef SD_ADC_CTRL_FRAME_CNT_EN
         r_frame     <= '0;
         r_out_frame <= '0;
`endif
      end else if (!en) begin
         r_dsel      <= dec_sel;
         r_cnt       <= '0;
         r_state     <= S_IDLE;
         r_ch        <= '0;
         r_settle    <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_overrun   <= 1'b0;
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            r_z1[k] <= '0;
            r_z2[k] <= '0;
            r_z3[k] <= '0;
         end
`ifdef SD_ADC_CTRL_FRAME_CNT_EN
         r_frame     <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_cnt   <= (r_cnt == w_cnt_max) ? '0 : r_cnt + CW'(1);
         if (w_ovr) begin
            r_overrun   <= 1'b1;
            r_out_valid <= 1'b0;
            r_settle    <= '0;
            r_ch        <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
               r_z1[k] <= '0;
               r_z2[k] <= '0;
               r_z3[k] <= '0;
            end
         end else begin
            if (w_tick) begin
               r_ch <= '0;
               for (int unsigned k = 0; k < NUM_CH; k++) r_cap[k] <= cn_in[k*DW +: DW];
`ifdef SD_ADC_CTRL_FRAME_CNT_EN
               if (w_settled) r_frame <= r_frame + 16'd1;
`endif
            end
            case (r_state)
               S_C1: begin
                  r_d1       <= w_d1;
                  r_z1[w_ci] <= r_cap[w_ci];
               end
               S_C2: begin
                  r_d2       <= w_d2;
                  r_z2[w_ci] <= r_d1;
               end
               S_C3: begin
                  r_z3[w_ci] <= r_d2;
                  if (w_settled) begin
                     r_out_data  <= w_d3;
                     r_out_ch    <= r_ch;
                     r_out_valid <= 1'b1;
`ifdef SD_ADC_CTRL_FRAME_CNT_EN
                     r_out_frame <= r_frame;
`endif
                  end
               end
               S_OUT: if (out_ready) r_out_valid <= 1'b0;
               default: ;
            endcase
            if (w_adv) begin
               if (w_last) r_settle <= w_settled ? r_settle : r_settle + 2'd1;
               else        r_ch     <= r_ch + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_psg_ecfs_lvdcdc_sd_adc_ctrl.sv
// Directed self-checking bench for psg_ecfs_lvdcdc_sd_adc_ctrl with a free-running Sinc3 integrator model.
module tb_psg_ecfs_lvdcdc_sd_adc_ctrl;
   localparam int unsigned NUM_CH = 4;
   localparam int unsigned DW     = 22;

   logic                 clk_adc = 1'b0;
   logic                 reset   = 1'b1;
   logic                 en      = 1'b0;
   logic [1:0]           dec_sel = 2'd0;
   logic [NUM_CH*DW-1:0] cn_in;
   logic [DW-1:0]        out_data;
   logic [2:0]           out_ch;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic                 busy;
   logic                 overrun;
`ifdef SD_ADC_CTRL_FRAME_CNT_EN
   logic [15:0]          out_frame;
`endif

   int checks   = 0;
   int failures = 0;

   logic [1:0]    mode [NUM_CH];
   logic [DW-1:0] i1 [NUM_CH];
   logic [DW-1:0] i2 [NUM_CH];
   logic [DW-1:0] i3 [NUM_CH];
   logic          tgl    = 1'b0;
   logic          tb_ld  = 1'b1;
   logic [DW-1:0] ld_val = '0;

   always #5 clk_adc = ~clk_adc;

   psg_ecfs_lvdcdc_sd_adc_ctrl #(.NUM_CH(NUM_CH), .DW(DW)) dut (
      .clk_adc   (clk_adc),
      .reset     (reset),
      .en        (en),
      .dec_sel   (dec_sel),
      .cn_in     (cn_in),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .overrun   (overrun)
`ifdef SD_ADC_CTRL_FRAME_CNT_EN
      ,
      .out_frame (out_frame)
`endif
   );

   function automatic logic [DW-1:0] bitval(input logic [1:0] m, input logic t);
      return ((m == 2'd1) || ((m == 2'd2) && t)) ? DW'(1) : DW'(0);
   endfunction

   // Three cascaded integrators per channel, modulator bitstream selected by mode
   always @(posedge clk_adc) begin
      tgl <= ~tgl;
      for (int k = 0; k < NUM_CH; k++) begin
         if (tb_ld) begin
            i1[k] <= '0;
            i2[k] <= '0;
            i3[k] <= ld_val;
         end else begin
            i1[k] <= i1[k] + bitval(mode[k], tgl);
            i2[k] <= i2[k] + i1[k];
            i3[k] <= i3[k] + i2[k];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cn
      assign cn_in[g*DW +: DW] = i3[g];
   end

   task automatic step();
      @(posedge clk_adc);
      @(negedge clk_adc);
   endtask

   // Disable, latch dec_sel, restart integrators from ld, then enable
   task automatic restart(input logic [1:0] dsel, input logic [DW-1:0] lv);
      en      = 1'b0;
      dec_sel = dsel;
      ld_val  = lv;
      tb_ld   = 1'b1;
      step();
      step();
      tb_ld = 1'b0;
      en    = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en    = 1'b0;
      step();
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (overrun !== 1'b0)   begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
      checks++; if (out_data !== '0)    begin failures++; $display("FAIL reset_data got=%0d exp=0", out_data); end
      checks++; if (out_ch !== 3'd0)    begin failures++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_settle_d32();
      int f, off;
      logic vexp, bexp;
      for (int k = 0; k < NUM_CH; k++) mode[k] = 2'd1;
      out_ready = 1'b1;
      restart(2'd0, '0);
      for (int e = 1; e <= 5*32 + 4; e++) begin
         step();
         f    = e / 32;
         off  = e % 32;
         vexp = (f >= 4) && (off >= 3) && (off <= 15) && (((off - 3) % 4) == 0);
         bexp = (f >= 1) && (off < ((f >= 4) ? 16 : 12));
         checks++;
         if (out_valid !== vexp) begin failures++; $display("FAIL d32_valid e=%0d got=%0b exp=%0b", e, out_valid, vexp); end
         checks++;
         if (busy !== bexp) begin failures++; $display("FAIL d32_busy e=%0d got=%0b exp=%0b", e, busy, bexp); end
         if (vexp) begin
            checks++;
            if (out_ch !== 3'((off - 3) / 4)) begin failures++; $display("FAIL d32_ch e=%0d got=%0d exp=%0d", e, out_ch, (off - 3) / 4); end
            checks++;
            if (out_data !== DW'(32768)) begin failures++; $display("FAIL d32_data e=%0d got=%0d exp=32768", e, out_data); end
         end
      end
   endtask

   task automatic test_dec128(input logic [1:0] dsel);
      logic [DW-1:0] exp_d [NUM_CH];
      int n, first;
      mode[0] = 2'd1; mode[1] = 2'd0; mode[2] = 2'd2; mode[3] = 2'd1;
      exp_d[0] = DW'(2097152); exp_d[1] = DW'(0); exp_d[2] = DW'(1048576); exp_d[3] = DW'(2097152);
      out_ready = 1'b1;
      restart(dsel, '0);
      n = 0;
      first = -1;
      for (int e = 1; e <= 4*128 + 40 && n < NUM_CH; e++) begin
         step();
         if (out_valid) begin
            if (first < 0) first = e;
            checks++;
            if (out_ch !== 3'(n)) begin failures++; $display("FAIL d128_ch sel=%0d got=%0d exp=%0d", dsel, out_ch, n); end
            checks++;
            if (out_data !== exp_d[n]) begin failures++; $display("FAIL d128_data sel=%0d ch=%0d got=%0d exp=%0d", dsel, n, out_data, exp_d[n]); end
            n++;
         end
      end
      checks++;
      if (first != 4*128 + 3) begin failures++; $display("FAIL d128_first sel=%0d got=%0d exp=%0d", dsel, first, 4*128 + 3); end
      checks++;
      if (n != NUM_CH) begin failures++; $display("FAIL d128_count sel=%0d got=%0d exp=%0d", dsel, n, NUM_CH); end
   endtask

   task automatic test_wrap();
      int n;
      for (int k = 0; k < NUM_CH; k++) mode[k] = 2'd1;
      out_ready = 1'b1;
      restart(2'd1, DW'(2194304));
      n = 0;
      for (int e = 1; e <= 4*64 + 40 && n < NUM_CH; e++) begin
         step();
         if (out_valid) begin
            checks++;
            if (e != 4*64 + 3 + 4*n) begin failures++; $display("FAIL wrap_time ch=%0d got=%0d exp=%0d", n, e, 4*64 + 3 + 4*n); end
            checks++;
            if (out_data !== DW'(262144)) begin failures++; $display("FAIL wrap_data ch=%0d got=%0d exp=262144", n, out_data); end
            n++;
         end
      end
      checks++;
      if (n != NUM_CH) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", n, NUM_CH); end
   endtask

   task automatic test_overrun();
      int e, first;
      for (int k = 0; k < NUM_CH; k++) mode[k] = 2'd1;
      out_ready = 1'b1;
      restart(2'd0, '0);
      e = 0;
      while (e < 4*32 + 20 && !(out_valid && out_ch == 3'd1)) begin
         step();
         e++;
      end
      checks++;
      if (e != 4*32 + 7) begin failures++; $display("FAIL ovr_ch1_time got=%0d exp=%0d", e, 4*32 + 7); end
      out_ready = 1'b0;
      while (e < 5*32 - 1) begin step(); e++; end
      checks++;
      if (overrun !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL ovr_hold ovr=%0b valid=%0b exp ovr=0 valid=1", overrun, out_valid); end
      step(); e++;
      checks++;
      if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%0b exp=1", overrun); end
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ovr_abort valid=%0b busy=%0b exp 0 0", out_valid, busy); end
      while (e < 5*32 + 15) begin step(); e++; end
      out_ready = 1'b1;
      first = -1;
      while (e < 9*32 + 20 && first < 0) begin
         step(); e++;
         if (out_valid) first = e;
      end
      checks++;
      if (first != 9*32 + 3) begin failures++; $display("FAIL ovr_resettle got=%0d exp=%0d", first, 9*32 + 3); end
      checks++;
      if (out_ch !== 3'd0 || out_data !== DW'(32768)) begin failures++; $display("FAIL ovr_data ch=%0d data=%0d exp ch=0 data=32768", out_ch, out_data); end
      checks++;
      if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
      en = 1'b0;
      step();
      checks++;
      if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%0b exp=0", overrun); end
   endtask

   task automatic test_en_fall();
      int e, first;
      for (int k = 0; k < NUM_CH; k++) mode[k] = 2'd1;
      out_ready = 1'b1;
      restart(2'd0, '0);
      e = 0;
      while (e < 4*32 + 20 && !(out_valid && out_ch == 3'd1)) begin step(); e++; end
      step();
      step();
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL enf_busy_c2 got=%0b exp=1", busy); end
      en      = 1'b0;
      dec_sel = 2'd1;
      step();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL enf_drop valid=%0b busy=%0b exp 0 0", out_valid, busy); end
      step();
      en = 1'b1;
      first = -1;
      for (int k = 1; k <= 80 && first < 0; k++) begin
         step();
         if (busy) first = k;
      end
      checks++;
      if (first != 64) begin failures++; $display("FAIL enf_tick64 got=%0d exp=64", first); end
   endtask

   task automatic test_reset_mid();
      int e, first;
      for (int k = 0; k < NUM_CH; k++) mode[k] = 2'd1;
      out_ready = 1'b0;
      restart(2'd0, '0);
      e = 0;
      while (e < 4*32 + 20 && !out_valid) begin step(); e++; end
      checks++;
      if (e != 4*32 + 3 || out_data !== DW'(32768)) begin failures++; $display("FAIL rmid_pre e=%0d data=%0d exp e=%0d data=32768", e, out_data, 4*32 + 3); end
      dec_sel = 2'd1;
      reset   = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0b exp=0", out_valid); end
      checks++; if (out_data !== '0)    begin failures++; $display("FAIL rmid_data got=%0d exp=0", out_data); end
      checks++; if (out_ch !== 3'd0)    begin failures++; $display("FAIL rmid_ch got=%0d exp=0", out_ch); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
      checks++; if (overrun !== 1'b0)   begin failures++; $display("FAIL rmid_overrun got=%0b exp=0", overrun); end
      reset     = 1'b0;
      out_ready = 1'b1;
      first = -1;
      for (int k = 1; k <= 80 && first < 0; k++) begin
         step();
         if (busy) first = k;
      end
      checks++;
      if (first != 64) begin failures++; $display("FAIL rmid_relatch got=%0d exp=64", first); end
   endtask

   initial begin
      for (int k = 0; k < NUM_CH; k++) mode[k] = 2'd1;
      test_reset();
      test_settle_d32();
      test_dec128(2'd2);
      test_dec128(2'd3);
      test_wrap();
      test_overrun();
      test_en_fall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
